instr_fetch_unit: RTL and testbench

//   Fetch stage upstream of BranchFacility. Latches the next instruction address,

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding Instruction Identify.
// Holds the fetch address, issues one 32-bit read per instruction, presents the
// returned word, and stalls BranchFacility until that word is consumed.
// Addresses use [0:63] numbering, where bit 63 is the least significant bit.
module instr_fetch_unit #(
  parameter logic [0:63] RESET_ADDR = 64'h0,
  parameter int          TIMEOUT    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_32b_mode,
  input  logic [0:63] i_next_instr_addr,
  output logic        o_stall,
  input  logic        i_flush,
  input  logic [0:63] i_flush_addr,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [0:63] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_mem_rsp_err,
  input  logic        i_id_stall,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [0:63] o_instr_addr,
  output logic        o_err_misaligned,
  output logic        o_err_fetch,
  output logic        o_err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DELIVER,
    S_DROP,
    S_HALT
  } state_t;

  state_t        r_state;
  logic [0:63]   r_pc;
  logic [TW-1:0] r_timer;

  logic w_misaligned;
  logic w_req_fire;
  logic w_timer_expired;

  assign w_misaligned    = (r_pc[62:63] != 2'b00);
  assign w_timer_expired = (r_timer == TW'(TIMEOUT - 1));

  // A misaligned pc never reaches the bus. The request is also held off while
  // reset is asserted, even though the state already reads S_REQ.
  assign o_mem_req_valid = (r_state == S_REQ) && !w_misaligned && !i_rst;
  assign o_mem_req_addr  = i_32b_mode ? {32'h0, r_pc[32:63]} : r_pc;
  assign w_req_fire      = o_mem_req_valid && i_mem_req_ready;

  // A flush suppresses delivery in that cycle. The stall is the exact
  // complement of valid, so the two are never asserted together.
  assign o_instr_valid = (r_state == S_DELIVER) && !i_id_stall && !i_flush;
  assign o_stall       = !o_instr_valid;

  // The fetch FSM. It also owns the pc, the response timer, the captured
  // instruction and the sticky error flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_REQ;
      r_pc             <= RESET_ADDR;
      r_timer          <= '0;
      o_instr          <= 32'h0;
      o_instr_addr     <= 64'h0;
      o_err_misaligned <= 1'b0;
      o_err_fetch      <= 1'b0;
      o_err_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_flush) begin
            // If the request was accepted in this same cycle, its response
            // is still owed to us and must be dropped.
            r_pc    <= i_flush_addr;
            r_timer <= '0;
            r_state <= w_req_fire ? S_DROP : S_REQ;
          end else if (w_misaligned) begin
            o_err_misaligned <= 1'b1;
            r_state          <= S_HALT;
          end else if (w_req_fire) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_flush) begin
            r_pc <= i_flush_addr;
            if (i_mem_rsp_valid) begin
              r_state <= S_REQ;
            end else begin
              // Saturate at the limit so that S_DROP still detects it.
              r_timer <= w_timer_expired ? r_timer : r_timer + 1'b1;
              r_state <= S_DROP;
            end
          end else if (i_mem_rsp_valid) begin
            if (i_mem_rsp_err) begin
              o_err_fetch <= 1'b1;
              r_state     <= S_HALT;
            end else begin
              o_instr      <= i_mem_rsp_data;
              o_instr_addr <= r_pc;
              r_state      <= S_DELIVER;
            end
          end else if (w_timer_expired) begin
            o_err_timeout <= 1'b1;
            r_state       <= S_HALT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DELIVER: begin
          if (i_flush) begin
            r_pc    <= i_flush_addr;
            r_state <= S_REQ;
          end else if (!i_id_stall) begin
            r_pc    <= i_next_instr_addr;
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_flush) begin
            r_pc <= i_flush_addr;
          end
          if (i_mem_rsp_valid) begin
            r_state <= S_REQ;
          end else if (w_timer_expired) begin
            o_err_timeout <= 1'b1;
            r_state       <= S_HALT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Memory and Identify are modelled by
// hand, step by step. Expected values are computed by hand for every step.
module tb_instr_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_32b_mode;
  logic [0:63] i_next_instr_addr;
  logic        o_stall;
  logic        i_flush;
  logic [0:63] i_flush_addr;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [0:63] o_mem_req_addr;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        i_mem_rsp_err;
  logic        i_id_stall;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [0:63] o_instr_addr;
  logic        o_err_misaligned;
  logic        o_err_fetch;
  logic        o_err_timeout;

  int compareCount  = 0;
  int mismatchCount = 0;

  instr_fetch_unit #(.RESET_ADDR(64'h0), .TIMEOUT(16)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_32b_mode        (i_32b_mode),
    .i_next_instr_addr (i_next_instr_addr),
    .o_stall           (o_stall),
    .i_flush           (i_flush),
    .i_flush_addr      (i_flush_addr),
    .o_mem_req_valid   (o_mem_req_valid),
    .i_mem_req_ready   (i_mem_req_ready),
    .o_mem_req_addr    (o_mem_req_addr),
    .i_mem_rsp_valid   (i_mem_rsp_valid),
    .i_mem_rsp_data    (i_mem_rsp_data),
    .i_mem_rsp_err     (i_mem_rsp_err),
    .i_id_stall        (i_id_stall),
    .o_instr_valid     (o_instr_valid),
    .o_instr           (o_instr),
    .o_instr_addr      (o_instr_addr),
    .o_err_misaligned  (o_err_misaligned),
    .o_err_fetch       (o_err_fetch),
    .o_err_timeout     (o_err_timeout)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clk = ~i_clk;

  // Advance past the next rising edge. Inputs are driven after this point.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Let combinational outputs settle after new inputs are driven.
  task automatic applyStimulus();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset for two cycles with all inputs idle.
  task automatic doReset();
    i_rst = 1'b1; i_32b_mode = 1'b0; i_next_instr_addr = 64'h0;
    i_flush = 1'b0; i_flush_addr = 64'h0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'h0; i_mem_rsp_err = 1'b0;
    i_id_stall = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted.
    doReset();
    applyStimulus();
    checkOutput("rst_req_valid", o_mem_req_valid, 0);
    checkOutput("rst_stall", o_stall, 1);
    checkOutput("rst_instr", o_instr, 0);
    checkOutput("rst_instr_addr", o_instr_addr, 0);
    checkOutput("rst_errs", {o_err_misaligned, o_err_fetch, o_err_timeout}, 0);
    i_rst = 1'b0;

    // 1: first fetch from address 0 with a zero-wait memory.
    i_mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("t1_req_valid", o_mem_req_valid, 1);
    checkOutput("t1_req_addr", o_mem_req_addr, 64'h0);
    checkOutput("t1_stall_req", o_stall, 1);
    tick();
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h48000010;
    applyStimulus();
    checkOutput("t1_wait_no_req", o_mem_req_valid, 0);
    checkOutput("t1_wait_no_valid", o_instr_valid, 0);
    tick();
    i_mem_rsp_valid = 1'b0; i_next_instr_addr = 64'h4;
    applyStimulus();
    checkOutput("t1_instr_valid", o_instr_valid, 1);
    checkOutput("t1_instr", o_instr, 32'h48000010);
    checkOutput("t1_instr_addr", o_instr_addr, 64'h0);
    checkOutput("t1_stall_deliver", o_stall, 0);
    tick();
    applyStimulus();
    checkOutput("t1_next_req_valid", o_mem_req_valid, 1);
    checkOutput("t1_next_req_addr", o_mem_req_addr, 64'h4);
    checkOutput("t1_valid_dropped", o_instr_valid, 0);

    // 2: memory not ready for 5 cycles; the request must hold steady.
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", o_mem_req_valid, 1);
      checkOutput("t2_hold_addr", o_mem_req_addr, 64'h4);
      checkOutput("t2_hold_stall", o_stall, 1);
      tick();
    end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h60000000;
    tick();
    i_mem_rsp_valid = 1'b0;

    // 3: Identify stalls for 3 cycles. The wandering nia must not leak into pc.
    i_id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_next_instr_addr = 64'h20 + 64'(i * 4);
      applyStimulus();
      checkOutput("t3_stall_valid", o_instr_valid, 0);
      checkOutput("t3_stall_stall", o_stall, 1);
      checkOutput("t3_stall_instr", o_instr, 32'h60000000);
      tick();
    end
    i_id_stall = 1'b0; i_next_instr_addr = 64'h8;
    applyStimulus();
    checkOutput("t3_release_valid", o_instr_valid, 1);
    checkOutput("t3_instr_addr", o_instr_addr, 64'h4);
    tick();
    applyStimulus();
    checkOutput("t3_next_req_addr", o_mem_req_addr, 64'h8);

    // 4: flush while waiting; the stale response is dropped and fetch restarts at 0x100.
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0; i_flush = 1'b1; i_flush_addr = 64'h100;
    tick();
    i_flush = 1'b0;
    applyStimulus();
    checkOutput("t4_drop_no_req", o_mem_req_valid, 0);
    checkOutput("t4_drop_stall", o_stall, 1);
    i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'hDEADBEEF;
    tick();
    i_mem_rsp_valid = 1'b0;
    applyStimulus();
    checkOutput("t4_restart_valid", o_mem_req_valid, 1);
    checkOutput("t4_restart_addr", o_mem_req_addr, 64'h100);
    checkOutput("t4_no_stale_valid", o_instr_valid, 0);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h38600001;
    tick();
    i_mem_rsp_valid = 1'b0; i_next_instr_addr = 64'h102;
    applyStimulus();
    checkOutput("t4_instr_valid", o_instr_valid, 1);
    checkOutput("t4_instr", o_instr, 32'h38600001);
    checkOutput("t4_instr_addr", o_instr_addr, 64'h100);
    tick();

    // 5a: misaligned nia 0x102. No request is issued and the fetch halts.
    i_mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("t5_misaligned_no_req", o_mem_req_valid, 0);
    tick();
    i_mem_req_ready = 1'b0;
    applyStimulus();
    checkOutput("t5_err_misaligned", o_err_misaligned, 1);
    tick();
    tick();
    checkOutput("t5_halt_no_req", o_mem_req_valid, 0);
    checkOutput("t5_halt_stall", o_stall, 1);
    checkOutput("t5_err_sticky", o_err_misaligned, 1);

    // 5b: a response carrying a bus error sets o_err_fetch and halts.
    doReset();
    i_rst = 1'b0;
    applyStimulus();
    checkOutput("t5_reset_clears_err", o_err_misaligned, 0);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b1; i_mem_rsp_err = 1'b1;
    i_mem_rsp_data = 32'h12345678;
    tick();
    i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
    i_flush = 1'b1; i_flush_addr = 64'h0;
    applyStimulus();
    checkOutput("t5_err_fetch", o_err_fetch, 1);
    checkOutput("t5_err_instr_not_captured", o_instr, 0);
    tick();
    i_flush = 1'b0;
    applyStimulus();
    checkOutput("t5_halt_ignores_flush", o_mem_req_valid, 0);

    // 6: 32-bit mode masks the upper address half. A silent memory then times out.
    doReset();
    i_rst = 1'b0; i_32b_mode = 1'b1;
    i_flush = 1'b1; i_flush_addr = 64'hFFFF_0000_0000_0040;
    tick();
    i_flush = 1'b0;
    applyStimulus();
    checkOutput("t6_req_valid", o_mem_req_valid, 1);
    checkOutput("t6_req_addr_masked", o_mem_req_addr, 64'h40);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checkOutput("t6_no_timeout_yet", o_err_timeout, 0);
    checkOutput("t6_wait_stall", o_stall, 1);
    tick();
    checkOutput("t6_err_timeout", o_err_timeout, 1);
    checkOutput("t6_no_fetch_err", o_err_fetch, 0);
    checkOutput("t6_halt_no_req", o_mem_req_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
